// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM state encoding,
// ALU operation select codes and the default datapath width.
// Imported by alu_seq_ctrl and alu_flag_gen.
package alu_seq_pkg;

  localparam int ALU_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // ALU operation select codes (cmd_op / alu_h)
  localparam logic [2:0] OP_PASS_A = 3'b000;  // A
  localparam logic [2:0] OP_ADD    = 3'b001;  // A + B
  localparam logic [2:0] OP_ADD_NB = 3'b010;  // A + ~B
  localparam logic [2:0] OP_DEC    = 3'b011;  // A - 1
  localparam logic [2:0] OP_AND    = 3'b100;  // A & B
  localparam logic [2:0] OP_OR     = 3'b101;  // A | B
  localparam logic [2:0] OP_XOR    = 3'b110;  // A ^ B
  localparam logic [2:0] OP_NOT_A  = 3'b111;  // ~A

endpackage

// File: rtl/alu_flag_gen.sv
// Purpose : zero / negative flags for an ALU result.
// Latency : combinational.
// Backpressure: none (pure function of res).
// Ports   : res (WIDTH result in), zero (res == 0), neg (res MSB).
module alu_flag_gen
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_W_DEF
) (
  input  logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg
);

  assign zero = (res == '0);
  assign neg  = res[WIDTH-1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Purpose : sequences commands through an external combinational ALU,
//           keeps an accumulator, captures the result with zero/neg flags.
// Latency : command accepted at edge k -> res_valid high after edge k+1,
//           seen at edge k+2; one command per 3 cycles at best.
// Backpressure: res_ready low holds the result and flags; cmd_ready stays
//           low until the result handshake completes.
// Ports   : clk/rst_n (async active-low); cmd_* command handshake and
//           fields; acc_clr accumulator clear (IDLE only, beats cmd_valid);
//           alu_a/alu_b/alu_h/alu_cin registered ALU drive, alu_f ALU
//           result; res_* result handshake, data and flags; op_count.
// Config  : define ALU_SEQ_OPCOUNT_EN to build the saturating op_count
//           counter; otherwise op_count is tied to 0.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_cin,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_h,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_h_q, alu_h_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_zero_q, res_zero_d;
  logic             res_neg_q, res_neg_d;
  logic             flag_zero, flag_neg;
  logic             res_hs;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .res  (alu_f),
    .zero (flag_zero),
    .neg  (flag_neg)
  );

  // acc_clr wins over a same-cycle command, so it also masks cmd_ready.
  assign cmd_ready = (state_q == IDLE) && !acc_clr;
  assign res_hs    = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_h_d     = alu_h_q;
    alu_cin_d   = alu_cin_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    case (state_q)
      IDLE: begin
        if (acc_clr) begin
          acc_d = '0;
        end else if (cmd_valid) begin
          alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_h_d   = cmd_op;
          alu_cin_d = cmd_cin;
          state_d   = DRIVE;
        end
      end
      // alu_* have been stable for a full cycle; alu_f is settled here.
      DRIVE: begin
        res_data_d  = alu_f;
        acc_d       = alu_f;
        res_zero_d  = flag_zero;
        res_neg_d   = flag_neg;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_h_q     <= '0;
      alu_cin_q   <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_h_q     <= alu_h_d;
      alu_cin_q   <= alu_cin_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_h     = alu_h_q;
  assign alu_cin   = alu_cin_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_zero  = res_zero_q;
  assign res_neg   = res_neg_q;

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    op_count_d = op_count_q;
    if (res_hs && (op_count_q != '1)) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl, closing the loop through a 4-bit
// combinational ALU model. Build with ALU_SEQ_OPCOUNT_EN to cover op_count.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;
`ifdef ALU_SEQ_OPCOUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_cin, cmd_use_acc, acc_clr;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [W-1:0]  alu_a, alu_b, alu_f;
  logic [2:0]    alu_h;
  logic          alu_cin;
  logic          res_valid, res_ready, res_zero, res_neg;
  logic [W-1:0]  res_data;
  logic [CW-1:0] op_count;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_h(alu_h), .alu_cin(alu_cin),
    .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_neg(res_neg), .op_count(op_count)
  );

  // 4-bit ALU attached to the sequencer; carry-in feeds the arithmetic ops.
  always_comb begin
    alu_f = '0;
    case (alu_h)
      OP_PASS_A: alu_f = alu_a + {3'b000, alu_cin};
      OP_ADD:    alu_f = alu_a + alu_b + {3'b000, alu_cin};
      OP_ADD_NB: alu_f = alu_a + ~alu_b + {3'b000, alu_cin};
      OP_DEC:    alu_f = alu_a - 4'd1 + {3'b000, alu_cin};
      OP_AND:    alu_f = alu_a & alu_b;
      OP_OR:     alu_f = alu_a | alu_b;
      OP_XOR:    alu_f = alu_a ^ alu_b;
      default:   alu_f = ~alu_a;
    endcase
  end

  task automatic note_hs();
    if (CNT_EN && exp_cnt < 255) exp_cnt++;
  endtask

  // Presents a command and returns 1 edge+1 after it is accepted.
  task automatic send_cmd(input logic [2:0] op, input logic cin,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic use_acc, output logic ok);
    ok = 1'b0;
    cmd_op = op; cmd_cin = cin; cmd_a = a; cmd_b = b;
    cmd_use_acc = use_acc; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // Full operation with res_ready high; returns the captured result.
  task automatic run_op(input logic [2:0] op, input logic cin,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_acc, output logic [W-1:0] data,
                        output logic z, output logic n, output logic ok);
    logic acc_ok;
    ok = 1'b0;
    send_cmd(op, cin, a, b, use_acc, acc_ok);
    if (acc_ok) begin
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (res_valid) begin ok = 1'b1; break; end
      end
    end
    data = res_data; z = res_zero; n = res_neg;
    if (ok) begin
      @(posedge clk); #1;
      note_hs();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_cin = 0; cmd_a = 0;
    cmd_b = 0; cmd_use_acc = 0; acc_clr = 0; res_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({alu_a, alu_b, alu_h, alu_cin, res_valid, res_data, res_zero, res_neg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h h=%h cin=%b v=%b d=%h z=%b n=%b, want all 0",
               alu_a, alu_b, alu_h, alu_cin, res_valid, res_data, res_zero, res_neg);
    end
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL reset_op_count: got %0d want 0", op_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic ok;
    send_cmd(OP_ADD, 1'b0, 4'b0001, 4'b0010, 1'b0, ok);
    checks++;
    if (!ok || res_valid !== 1'b0 || alu_a !== 4'b0001 || alu_b !== 4'b0010 || alu_h !== OP_ADD) begin
      errors++;
      $display("FAIL add_drive: ok=%b v=%b a=%b b=%b h=%b, want ok=1 v=0 a=0001 b=0010 h=001",
               ok, res_valid, alu_a, alu_b, alu_h);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL add_latency: v=%b rdy=%b want v=1 rdy=0", res_valid, cmd_ready);
    end
    checks++;
    if (res_data !== 4'b0011 || res_zero !== 1'b0 || res_neg !== 1'b0) begin
      errors++; $display("FAIL add_result: d=%b z=%b n=%b want 0011 0 0", res_data, res_zero, res_neg);
    end
    @(posedge clk); #1;
    note_hs();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL add_release: v=%b rdy=%b want v=0 rdy=1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_use_acc();
    logic [W-1:0] d; logic z, n, ok;
    run_op(OP_ADD, 1'b0, 4'b1111, 4'b0010, 1'b1, d, z, n, ok);
    checks++;
    if (!ok || d !== 4'b0101 || z !== 1'b0 || n !== 1'b0) begin
      errors++; $display("FAIL use_acc_add: ok=%b d=%b z=%b n=%b want 1 0101 0 0", ok, d, z, n);
    end
  endtask

  task automatic test_flags();
    logic [W-1:0] d; logic z, n, ok;
    run_op(OP_NOT_A, 1'b0, 4'b0001, 4'b0000, 1'b0, d, z, n, ok);
    checks++;
    if (!ok || d !== 4'b1110 || z !== 1'b0 || n !== 1'b1) begin
      errors++; $display("FAIL not_neg: ok=%b d=%b z=%b n=%b want 1 1110 0 1", ok, d, z, n);
    end
    run_op(OP_DEC, 1'b0, 4'b0001, 4'b0000, 1'b0, d, z, n, ok);
    checks++;
    if (!ok || d !== 4'b0000 || z !== 1'b1 || n !== 1'b0) begin
      errors++; $display("FAIL dec_zero: ok=%b d=%b z=%b n=%b want 1 0000 1 0", ok, d, z, n);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    res_ready = 1'b0;
    send_cmd(OP_XOR, 1'b0, 4'b0110, 4'b0011, 1'b0, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || res_valid !== 1'b1 || res_data !== 4'b0101) begin
      errors++; $display("FAIL bp_first: ok=%b v=%b d=%b want 1 1 0101", ok, res_valid, res_data);
    end
    // Pending command while the result is stalled.
    cmd_op = OP_PASS_A; cmd_cin = 1'b0; cmd_a = 4'b1001; cmd_b = 4'b0000;
    cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 4'b0101 || cmd_ready !== 1'b0 || alu_a !== 4'b0110) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b d=%b rdy=%b a=%b want 1 0101 0 0110",
                 i, res_valid, res_data, cmd_ready, alu_a);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    note_hs();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 4'b0110) begin
      errors++; $display("FAIL bp_release: v=%b rdy=%b a=%b want 0 1 0110", res_valid, cmd_ready, alu_a);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 4'b1001) begin
      errors++; $display("FAIL bp_pending_accept: a=%b want 1001", alu_a);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'b1001) begin
      errors++; $display("FAIL bp_pending_result: v=%b d=%b want 1 1001", res_valid, res_data);
    end
    @(posedge clk); #1;
    note_hs();
  endtask

  task automatic test_acc_clr();
    // Accumulator holds 1001 here.
    acc_clr = 1'b1;
    cmd_op = OP_PASS_A; cmd_cin = 1'b0; cmd_a = 4'b0111; cmd_b = 4'b0000;
    cmd_use_acc = 1'b1; cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL clr_blocks_ready: rdy=%b want 0", cmd_ready);
    end
    @(posedge clk); #1;
    acc_clr = 1'b0;
    checks++;
    if (alu_a !== 4'b1001 || res_valid !== 1'b0) begin
      errors++; $display("FAIL clr_not_accepted: a=%b v=%b want 1001 0", alu_a, res_valid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 4'b0000 || alu_h !== OP_PASS_A) begin
      errors++; $display("FAIL clr_acc_operand: a=%b h=%b want 0000 000", alu_a, alu_h);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 4'b0000 || res_zero !== 1'b1) begin
      errors++; $display("FAIL clr_result: v=%b d=%b z=%b want 1 0000 1", res_valid, res_data, res_zero);
    end
    @(posedge clk); #1;
    note_hs();
  endtask

  task automatic test_reset_mid_op();
    logic ok; logic [W-1:0] d; logic z, n;
    checks++;
    if (op_count !== CW'(exp_cnt)) begin
      errors++; $display("FAIL count_before_reset: got %0d want %0d", op_count, exp_cnt);
    end
    send_cmd(OP_PASS_A, 1'b0, 4'b0101, 4'b1010, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {alu_a, alu_b, alu_h, alu_cin, res_valid, res_data, res_zero, res_neg} !== '0
        || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_drive: ok=%b a=%h b=%h h=%h v=%b d=%h cnt=%0d want ok=1, all 0",
               ok, alu_a, alu_b, alu_h, res_valid, res_data, op_count);
    end
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || op_count !== 8'd0) begin
      errors++; $display("FAIL reset_aborted: v=%b cnt=%0d want 0 0", res_valid, op_count);
    end
    for (int i = 0; i < 3; i++) run_op(OP_OR, 1'b0, 4'b0100, 4'b0001, 1'b0, d, z, n, ok);
    checks++;
    if (!ok || d !== 4'b0101 || op_count !== CW'(CNT_EN ? 3 : 0)) begin
      errors++; $display("FAIL count_three: ok=%b d=%b cnt=%0d want 1 0101 %0d", ok, d, op_count, CNT_EN ? 3 : 0);
    end
    for (int i = 0; i < 255; i++) run_op(OP_AND, 1'b0, 4'b1100, 4'b1010, 1'b0, d, z, n, ok);
    checks++;
    if (!ok || d !== 4'b1000 || op_count !== CW'(CNT_EN ? 255 : 0)) begin
      errors++; $display("FAIL count_saturate: ok=%b d=%b cnt=%0d want 1 1000 %0d", ok, d, op_count, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_use_acc();
    test_flags();
    test_backpressure();
    test_acc_clr();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
